fp_adder_arbiter: RTL

Round-robin arbiter that shares one pipelined FP_adder instance among NUM_REQ requesters, such as the chaos-map iteration units and the pixel-diffusion stage. Each requester presents an operand pair with a valid/ready handshake. The arbiter issues at most one pair per cycle into the adder and tags it with the requester index. It carries the tag alongside the adder's fixed pipeline latency and returns each sum only to the requester that issued it. The adder itself has no valid signal; this block owns all occupancy tracking.

---
 rtl/fp_arb_pkg.sv | 25 ++
 rtl/fp_adder_arbiter_rr_arbiter.sv | 31 +++
 rtl/fp_adder_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP adder arbiter: tag-pipeline entry,
// default adder latency and a slice extractor for flattened operand buses.
package fp_arb_pkg;

  localparam int FP_ADD_LATENCY  = 4;
  localparam int FP_ARB_MAX_REQ  = 16;
  localparam int FP_ARB_MAX_PREC = 64;
  localparam int FP_ARB_TAG_W    = 4;
  localparam int FP_ARB_BUS_W    = FP_ARB_MAX_REQ * FP_ARB_MAX_PREC;

  // Tag width covers the full legal requester range; narrower configs zero-extend.
  typedef struct packed {
    logic                    valid;
    logic [FP_ARB_TAG_W-1:0] tag;
  } fp_arb_tag_t;

  function automatic logic [FP_ARB_BUS_W-1:0] fp_arb_slice(
    input logic [FP_ARB_BUS_W-1:0] bus,
    input int                      idx,
    input int                      width
  );
    return bus >> (idx * width);
  endfunction

endpackage

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational priority search starting at ptr_i and wrapping modulo NUM_REQ;
// returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [TAG_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [TAG_W-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = TAG_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fixed-latency FP adder among NUM_REQ requesters and routes each sum
// back by tag. Define FP_ARB_ROUND_ROBIN_EN for rotating priority; else fixed priority.
module fp_adder_arbiter
  import fp_arb_pkg::*;
#(
  parameter int PRECISION   = 32,
  parameter int EXPONENT    = 8,
  parameter int FRACTION    = 23,
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = FP_ADD_LATENCY,
  parameter int TAG_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*PRECISION-1:0] req_a,
  input  logic [NUM_REQ*PRECISION-1:0] req_b,
  output logic [PRECISION-1:0]         add_a,
  output logic [PRECISION-1:0]         add_b,
  input  logic [PRECISION-1:0]         add_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [PRECISION-1:0]         rsp_data,
  output logic                         busy
);

  if (NUM_REQ < 2 || NUM_REQ > FP_ARB_MAX_REQ) begin : g_bad_num_req
    $error("fp_adder_arbiter: NUM_REQ must be 2..16");
  end
  if (EXPONENT + FRACTION + 1 != PRECISION || PRECISION > FP_ARB_MAX_PREC) begin : g_bad_fmt
    $error("fp_adder_arbiter: PRECISION must equal 1+EXPONENT+FRACTION and be <= 64");
  end

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [TAG_W-1:0]     gnt_idx;
  logic [TAG_W-1:0]     search_start;
  logic                 accept;
  logic [PRECISION-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [PRECISION-1:0] rsp_data_q, rsp_data_d;
  logic                 busy_c;
  // Stage 0 lines up with add_a/add_b; stage ADD_LATENCY lines up with add_result.
  fp_arb_tag_t          tag_q [ADD_LATENCY+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (search_start),
    .gnt_o (arb_gnt),
    .idx_o (gnt_idx)
  );

  // Handshake: requester i transfers its operand pair on a rising edge where
  // req_valid[i] && req_ready[i]; req_ready is never high without req_valid.
  assign req_ready = reset ? '0 : arb_gnt;
  assign accept    = |req_ready;

`ifdef FP_ARB_ROUND_ROBIN_EN
  logic [TAG_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign search_start = ptr_q;
`else
  assign search_start = '0;
`endif

  always_comb begin
    add_a_d = '0;
    add_b_d = '0;
    if (accept) begin
      add_a_d = PRECISION'(fp_arb_slice(FP_ARB_BUS_W'(req_a), int'(gnt_idx), PRECISION));
      add_b_d = PRECISION'(fp_arb_slice(FP_ARB_BUS_W'(req_b), int'(gnt_idx), PRECISION));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= ADD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, tag: FP_ARB_TAG_W'(gnt_idx)};
      for (int k = 1; k <= ADD_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[ADD_LATENCY].valid) begin
      rsp_valid_d = NUM_REQ'(1) << tag_q[ADD_LATENCY].tag;
      rsp_data_d  = add_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    busy_c = |rsp_valid_q;
    for (int k = 0; k <= ADD_LATENCY; k++) busy_c = busy_c | tag_q[k].valid;
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_c;

endmodule
